// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: fixed priority, optional starvation guard (WB_ARB_STARVE_GUARD_EN).
// Latency: one cycle from handshake to write_en_o; one write per cycle sustained.
// Backpressure: never stalls the winner; losers see ready low and must hold their request.
module wb_port_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NUM_REQ-1:0]                req_valid_i,
    input  logic [NUM_REQ-1:0][4:0]           req_rd_addr_i,
    input  logic [NUM_REQ-1:0][31:0]          req_data_i,
    output logic [NUM_REQ-1:0]                req_ready_o,
    output logic                              write_en_o,
    output logic [4:0]                        rd_addr_o,
    output logic [31:0]                       rd_data_o,
    output logic [31:0]                       wb_data_fwd_o,
    output logic [4:0]                        rd_addr_fwd_o,
    output logic                              reg_write_en_fwd_o,
    output logic [$clog2(NUM_REQ)-1:0]        grant_idx_o
);

    localparam int IW = $clog2(NUM_REQ);

    typedef logic [4:0]  reg_addr_t;
    typedef logic [31:0] word_t;

    logic [NUM_REQ-1:0] cand;
    logic               win_vld;
    logic [IW-1:0]      win_idx;

    logic               valid_q;
    reg_addr_t          rd_addr_q;
    word_t              data_q;
    logic [IW-1:0]      grant_q;

`ifdef WB_ARB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [NUM_REQ-1:0][CW-1:0] wait_q;
    logic [NUM_REQ-1:0]         starving;

    always_comb begin
        starving = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            starving[i] = req_valid_i[i] && (wait_q[i] == CW'(STARVE_LIMIT));
        end
    end

    // Starving requesters replace the whole candidate set, so they beat base priority.
    assign cand = (|starving) ? starving : req_valid_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid_i[i] && !req_ready_o[i]) begin
                    if (wait_q[i] != CW'(STARVE_LIMIT)) begin
                        wait_q[i] <= wait_q[i] + 1'b1;
                    end
                end else begin
                    wait_q[i] <= '0;
                end
            end
        end
    end
`else
    assign cand = req_valid_i;
`endif

    // Descending scan leaves the lowest set index as the winner.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (cand[i]) begin
                win_vld = 1'b1;
                win_idx = IW'(i);
            end
        end
    end

    assign req_ready_o = win_vld ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx) : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q   <= 1'b0;
            rd_addr_q <= '0;
            data_q    <= '0;
            grant_q   <= '0;
        end else if (win_vld) begin
            valid_q   <= 1'b1;
            rd_addr_q <= req_rd_addr_i[win_idx];
            data_q    <= req_data_i[win_idx];
            grant_q   <= win_idx;
        end else begin
            valid_q   <= 1'b0;
        end
    end

    // Writes to x0 are consumed but never reach the register file.
    assign write_en_o         = valid_q && (rd_addr_q != '0);
    assign rd_addr_o          = rd_addr_q;
    assign rd_data_o          = data_q;
    assign reg_write_en_fwd_o = write_en_o;
    assign rd_addr_fwd_o      = rd_addr_q;
    assign wb_data_fwd_o      = data_q;
    assign grant_idx_o        = grant_q;

    a_params: assert property (@(posedge clk_i)
        (NUM_REQ >= 2) && (NUM_REQ <= 8) && (STARVE_LIMIT >= 1) && (STARVE_LIMIT <= 255))
        else $error("wb_port_arbiter: parameter out of range");

    a_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(req_ready_o))
        else $error("wb_port_arbiter: more than one ready");

    a_no_x0: assert property (@(posedge clk_i) disable iff (!rst_ni) write_en_o |-> (rd_addr_o != '0))
        else $error("wb_port_arbiter: write enable towards x0");

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stable
        a_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
            (req_valid_i[g] && !req_ready_o[g]) |=>
                (req_valid_i[g] && $stable(req_rd_addr_i[g]) && $stable(req_data_i[g])))
            else $error("wb_port_arbiter: requester %0d changed before acceptance", g);
    end

endmodule
